// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage with single-outstanding imem handshake
module fetch_stage #(
  parameter int unsigned           WIDTH    = 32,
  parameter logic [WIDTH-1:0]      RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_f,
  output logic [WIDTH-1:0] pc_plus4_f,
  output logic [WIDTH-1:0] pc_f,
  output logic             f_valid
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] instr_buf, instr_buf_nxt;
  logic             valid_nxt;
  logic [WIDTH-1:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[WIDTH-1:2], 2'b00};
  assign pc_plus4_f   = pc_f + WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      pc_f      <= RESET_PC;
      instr_buf <= '0;
      f_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_f      <= pc_nxt;
      instr_buf <= instr_buf_nxt;
      f_valid   <= valid_nxt;
    end
  end

  // A redirect always retargets the PC; only the state transition depends on where the
  // outstanding transaction is, so a granted request is always drained before re-issuing.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_f;
    instr_buf_nxt = instr_buf;
    valid_nxt     = f_valid;
    if (redirect) pc_nxt = redirect_tgt;
    unique case (state)
      S_REQ: begin
        if (imem_gnt) state_nxt = redirect ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          instr_buf_nxt = imem_rdata;
          valid_nxt     = 1'b1;
          state_nxt     = S_VALID;
        end
      end
      S_VALID: begin
        if (redirect) begin
          valid_nxt = 1'b0;
          state_nxt = S_REQ;
        end else if (!stall_f) begin
          pc_nxt    = pc_plus4_f;
          valid_nxt = 1'b0;
          state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  assign imem_req  = (state == S_REQ) && !rst;
  assign imem_addr = pc_f;
  assign instr_f   = f_valid ? instr_buf : '0;

endmodule
